fetch_redirect_unit: RTL
========================

// Module: fetch_redirect_unit
// PURPOSE
//   Fetch-side consumer of control-flow redirects. Owns the IF-stage PC register and takes
//   jump targets from the ID-stage jump logic (j/jal/jr) and taken-branch targets from EX.
//   Arbitrates the two sources and buffers one redirect while fetch is stalled.
//   Generates the pipeline flushes that squash wrong-path instructions. No branch delay slot.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PCF value after reset
//   CNT_W      16             width of the redirect statistics counter
// PORTS
//   Clk            in   1      clock, rising edge
//   Rst_n          in   1      asynchronous reset, active low
//   StallF         in   1      hazard unit: hold PCF this cycle
//   JumpReq        in   1      ID stage: j/jal/jr target valid this cycle
//   JumpTarget     in   32     ID-stage jump address
//   BranchReq      in   1      EX stage: branch resolved taken this cycle
//   BranchTarget   in   32     EX-stage branch address
//   PCF            out  32     current fetch PC (registered)
//   PCPlus4F       out  32     PCF + 4 (combinational, modulo 2^32)
//   FlushD         out  1      squash IF/ID register at the next edge
//   FlushE         out  1      squash ID/EX register at the next edge
//   RedirectPending out 1      a buffered redirect is waiting on StallF
//   AlignErr       out  1      one-cycle pulse: the applied target had [1:0] != 0
//   RedirectCnt    out  CNT_W  number of applied redirects, saturating
// BEHAVIOUR
//   Reset (Rst_n=0, async): PCF=RESET_PC, pending cleared, state RUN, RedirectCnt=0, AlignErr=0.
//     FlushD and FlushE are 0 while in reset. A reset mid-stall discards the buffered redirect.
//   Source select each cycle: BranchReq beats JumpReq. A simultaneous jump is wrong-path: drop it.
//   State RUN (no pending):
//     StallF=0, request present -> PCF <= {target[31:2],2'b00} at this edge ("applied").
//     StallF=0, no request       -> PCF <= PCF+4. PCF wraps 32'hFFFF_FFFC -> 32'h0.
//     StallF=1, request present -> latch target and source into the buffer; PCF holds; go HOLD.
//     StallF=1, no request       -> PCF holds.
//   State HOLD (RedirectPending=1):
//     Pending jump, new BranchReq      -> overwrite the buffer with the branch.
//     Pending branch, any request      -> ignore it (younger, wrong path).
//     Pending jump, new JumpReq only   -> keep the existing buffer.
//     StallF=0 -> apply the buffered target (the branch if one arrives this cycle); go RUN.
//   Flushes: combinational, asserted only in the cycle a redirect is applied.
//     FlushD=1 for any applied redirect. FlushE=1 only when the applied source is a branch.
//     A request captured under StallF raises no flush until it is applied.
//   Latency: request in cycle n with StallF=0 -> PCF=target in cycle n+1.
//     Buffered redirect: PCF=target in the cycle after the first StallF=0 cycle.
//   AlignErr: registered; high for the cycle after an applied target with [1:0] != 0.
//     The low bits of that target are forced to 0.
//   RedirectCnt: +1 per applied redirect (immediate or buffered); holds at all-ones.
// TESTING
//   1. Reset with RESET_PC=0, no requests, 3 cycles -> PCF 0,4,8,12; FlushD=FlushE=0.
//   2. PCF=0x10, JumpReq=1, JumpTarget=0x400, StallF=0 -> FlushD=1, FlushE=0 that cycle;
//      next cycle PCF=0x400, PCPlus4F=0x404, RedirectCnt=1.
//   3. Same cycle: JumpReq=1 (0x400) and BranchReq=1 (0x80) -> FlushD=FlushE=1;
//      next cycle PCF=0x80.
//   4. StallF=1 for 3 cycles with JumpReq=1 (0x200) in cycle 1 and BranchReq=1 (0x300) in cycle 2
//      -> RedirectPending=1, PCF holds, no flushes; StallF=0 -> FlushD=FlushE=1,
//      PCF=0x300 next cycle, RedirectPending=0.
//   5. Pending jump buffered, Rst_n pulsed low mid-stall -> PCF=RESET_PC immediately,
//      RedirectPending=0; after release, sequential fetch from RESET_PC.
//   6. JumpTarget=0x1002, StallF=0 -> PCF=0x1000 and AlignErr=1 for one cycle;
//      PCF=0xFFFF_FFFC, no request -> PCF=0x0 next cycle.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// ----------------------------------------------------------------------------
// fetch_redirect_unit
//   Owns the IF-stage PC. Accepts jump targets from ID (j/jal/jr) and taken
//   branch targets from EX, picks one per cycle (branch wins, a same-cycle
//   jump is on the wrong path), buffers a single redirect while fetch is
//   stalled, and raises the flushes that squash wrong-path instructions.
//   No branch delay slot.
//
// Ports
//   Clk, Rst_n       clock (rising edge), asynchronous active-low reset
//   StallF           hold PCF this cycle
//   JumpReq/Target   ID-stage jump request and address
//   BranchReq/Target EX-stage taken-branch request and address
//   PCF              registered fetch PC
//   PCPlus4F         PCF + 4, combinational, wraps modulo 2^32
//   FlushD, FlushE   combinational squash of IF/ID and ID/EX at the next edge
//   RedirectPending  a buffered redirect is waiting for StallF to drop
//   AlignErr         one-cycle pulse after an applied target with [1:0] != 0
//   RedirectCnt      saturating count of applied redirects
// ----------------------------------------------------------------------------
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             StallF,
    input  logic             JumpReq,
    input  logic [31:0]      JumpTarget,
    input  logic             BranchReq,
    input  logic [31:0]      BranchTarget,
    output logic [31:0]      PCF,
    output logic [31:0]      PCPlus4F,
    output logic             FlushD,
    output logic             FlushE,
    output logic             RedirectPending,
    output logic             AlignErr,
    output logic [CNT_W-1:0] RedirectCnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pcf;
    logic [31:0]      r_buf_tgt;
    logic             r_buf_br;
    logic             r_align_err;
    logic [CNT_W-1:0] r_cnt;

    state_t      w_state_next;
    logic [31:0] w_buf_tgt_next;
    logic        w_buf_br_next;
    logic        w_req;
    logic [31:0] w_req_tgt;
    logic        w_apply;
    logic [31:0] w_apply_tgt;
    logic        w_apply_br;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;

    // Branch beats jump: a jump in ID alongside a taken branch in EX is younger
    // than the branch and therefore on the wrong path.
    assign w_req      = BranchReq | JumpReq;
    assign w_req_tgt  = BranchReq ? BranchTarget : JumpTarget;
    assign w_pc_plus4 = r_pcf + 32'd4;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        w_state_next   = r_state;
        w_buf_tgt_next = r_buf_tgt;
        w_buf_br_next  = r_buf_br;
        w_apply        = 1'b0;
        w_apply_tgt    = r_buf_tgt;
        w_apply_br     = r_buf_br;

        unique case (r_state)
            ST_RUN: begin
                if (w_req) begin
                    if (!StallF) begin
                        w_apply     = 1'b1;
                        w_apply_tgt = w_req_tgt;
                        w_apply_br  = BranchReq;
                    end else begin
                        w_state_next   = ST_HOLD;
                        w_buf_tgt_next = w_req_tgt;
                        w_buf_br_next  = BranchReq;
                    end
                end
            end
            ST_HOLD: begin
                // Only an older branch may displace a buffered jump; anything
                // arriving behind a buffered branch is wrong-path.
                if (!r_buf_br && BranchReq) begin
                    w_buf_tgt_next = BranchTarget;
                    w_buf_br_next  = 1'b1;
                end
                if (!StallF) begin
                    w_apply      = 1'b1;
                    w_apply_tgt  = w_buf_tgt_next;
                    w_apply_br   = w_buf_br_next;
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_comb begin
        if (w_apply)     w_pc_next = {w_apply_tgt[31:2], 2'b00};
        else if (StallF) w_pc_next = r_pcf;
        else             w_pc_next = w_pc_plus4;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= ST_RUN;
            r_pcf       <= RESET_PC;
            r_buf_tgt   <= 32'h0;
            r_buf_br    <= 1'b0;
            r_align_err <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pcf       <= w_pc_next;
            r_buf_tgt   <= w_buf_tgt_next;
            r_buf_br    <= w_buf_br_next;
            r_align_err <= w_apply && (w_apply_tgt[1:0] != 2'b00);
            if (w_apply && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign PCF             = r_pcf;
    assign PCPlus4F        = w_pc_plus4;
    // Flushes are gated by reset so nothing is squashed while Rst_n is low.
    assign FlushD          = w_apply & Rst_n;
    assign FlushE          = w_apply & w_apply_br & Rst_n;
    assign RedirectPending = (r_state == ST_HOLD);
    assign AlignErr        = r_align_err;
    assign RedirectCnt     = r_cnt;

endmodule
